// File: rtl/param_shift_add_multiplier_if.sv
// Handshake and operand bus between a requester and the shift-add multiplier.
// The requester drives the operands and start; the multiplier returns product and status.
interface param_shift_add_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 st;
  logic                 signed_i;
  logic [WIDTH-1:0]     mcand_i;
  logic [WIDTH-1:0]     mplier_i;
  logic [2*WIDTH-1:0]   product_o;
  logic                 busy;
  logic                 done;

  modport master (
    output st, signed_i, mcand_i, mplier_i,
    input  product_o, busy, done
  );

  modport slave (
    input  st, signed_i, mcand_i, mplier_i,
    output product_o, busy, done
  );
endinterface

// File: rtl/param_shift_add_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, unsigned or two's-complement.
// Fixed latency of WIDTH steps; product_o holds until the next operation completes.
module param_shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  param_shift_add_multiplier_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [WIDTH:0]       r_acc;
  logic [WIDTH-1:0]     r_mplier;
  logic [WIDTH-1:0]     r_mcand;
  logic                 r_signed;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_product;

  logic [WIDTH+1:0]     w_accExt;
  logic [WIDTH+1:0]     w_mcandExt;
  logic [WIDTH+1:0]     w_sum;
  logic                 w_lastStep;
  logic                 w_busy;
  logic                 w_done;

  // The sum is two bits wider than the operand so that bit WIDTH+1 is the
  // carry in unsigned mode and the true sign in signed mode; shifting it in
  // therefore gives both the carry insertion and the arithmetic shift.
  always_comb begin
    w_accExt   = r_signed ? {r_acc[WIDTH], r_acc} : {1'b0, r_acc};
    w_mcandExt = r_signed ? {{2{r_mcand[WIDTH-1]}}, r_mcand} : {2'b00, r_mcand};
    w_lastStep = (r_count == LAST_STEP);
    w_sum      = w_accExt;
    if (r_mplier[0]) begin
      if (r_signed && w_lastStep) begin
        w_sum = w_accExt - w_mcandExt;
      end else begin
        w_sum = w_accExt + w_mcandExt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.st) begin
          w_nextState = CALC;
        end
      end
      CALC: begin
        w_busy = 1'b1;
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mplier  <= '0;
      r_mcand   <= '0;
      r_signed  <= 1'b0;
      r_count   <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.st) begin
            r_acc    <= '0;
            r_mplier <= bus.mplier_i;
            r_mcand  <= bus.mcand_i;
            r_signed <= bus.signed_i;
            r_count  <= '0;
          end
        end
        CALC: begin
          r_acc    <= w_sum[WIDTH+1:1];
          r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
          r_count  <= r_count + 1'b1;
          if (w_lastStep) begin
            r_product <= {w_sum[WIDTH:0], r_mplier[WIDTH-1:1]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.product_o = r_product;
  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
endmodule

// File: tb/tb_param_shift_add_multiplier.sv
// Self-checking bench for param_shift_add_multiplier with WIDTH=4 and WIDTH=8 instances
// against an integer-arithmetic reference model.
module tb_param_shift_add_multiplier;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  param_shift_add_multiplier_if #(.WIDTH(4)) if4 ();
  param_shift_add_multiplier_if #(.WIDTH(8)) if8 ();

  param_shift_add_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  param_shift_add_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial forever #5 clk = ~clk;

  // Reference: plain integer product of the operands interpreted per mode.
  function automatic logic [63:0] refProduct(bit sgn, int w, logic [31:0] a, logic [31:0] b);
    longint mask = (longint'(1) << w) - 1;
    longint sa = longint'(a) & mask;
    longint sb = longint'(b) & mask;
    longint p;
    if (sgn) begin
      if (sa >= (longint'(1) << (w - 1))) sa -= (longint'(1) << w);
      if (sb >= (longint'(1) << (w - 1))) sb -= (longint'(1) << w);
    end
    p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
    return 64'(p);
  endfunction

  function automatic logic [63:0] curProd(int sel);
    return (sel == 0) ? 64'(if4.product_o) : 64'(if8.product_o);
  endfunction

  function automatic logic curBusy(int sel);
    return (sel == 0) ? if4.busy : if8.busy;
  endfunction

  function automatic logic curDone(int sel);
    return (sel == 0) ? if4.done : if8.done;
  endfunction

  task automatic setInputs(int sel, bit st, bit sgn, logic [31:0] a, logic [31:0] b);
    if (sel == 0) begin
      if4.st = st; if4.signed_i = sgn; if4.mcand_i = a[3:0]; if4.mplier_i = b[3:0];
    end else begin
      if8.st = st; if8.signed_i = sgn; if8.mcand_i = a[7:0]; if8.mplier_i = b[7:0];
    end
  endtask

  task automatic setSt(int sel, bit st);
    if (sel == 0) if4.st = st;
    else if8.st = st;
  endtask

  // Drive st for exactly one sampling edge (edge k); returns #1 after edge k.
  task automatic driveStart(int sel, bit sgn, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    setInputs(sel, 1'b1, sgn, a, b);
    @(posedge clk);
    #1;
    setSt(sel, 1'b0);
  endtask

  // Full operation: latency in edges after edge k, busy samples, and done pulse width check.
  task automatic runOp(input int sel, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] prod, output int lat, output int busyCyc, output bit doneOk);
    driveStart(sel, sgn, a, b);
    busyCyc = int'(curBusy(sel));
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (curDone(sel)) break;
      busyCyc += int'(curBusy(sel));
    end
    prod = curProd(sel);
    @(posedge clk);
    #1;
    doneOk = !curDone(sel) && !curBusy(sel);
  endtask

  task automatic test_reset();
    logic [63:0] prod;
    int lat;
    #1;
    rst_n = 1'b0;
    setInputs(0, 1'b1, 1'b0, 7, 11);
    setInputs(1, 1'b1, 1'b0, 255, 255);
    #1;
    vectors += 4;
    if (if4.product_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_prod4: got %0h expected 0", if4.product_o); end
    if (if4.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy4: got %b expected 0", if4.busy); end
    if (if4.done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done4: got %b expected 0", if4.done); end
    if (if8.product_o !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_prod8: got %0h expected 0", if8.product_o); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (if4.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL st_in_reset: busy got %b expected 0", if4.busy); end
    @(negedge clk);
    setSt(1, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (if4.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL first_edge_capture: busy got %b expected 1", if4.busy); end
    setSt(0, 1'b0);
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (if4.done) break;
    end
    prod = curProd(0);
    vectors += 2;
    if (lat != 4) begin miscompares++; $display("[TB] FAIL post_reset_latency: got %0d expected 4", lat); end
    if (prod !== 64'd77) begin miscompares++; $display("[TB] FAIL post_reset_prod: got %0h expected 4d", prod); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    int          dSel[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    bit          dSgn[10] = '{0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    logic [31:0] dA[10]   = '{7, 'hD, 8, 7, 15, 15, 255, 'h80, 0, 0};
    logic [31:0] dB[10]   = '{11, 5, 8, 'hF, 15, 15, 255, 'h80, 13, 'h9C};
    logic [63:0] dExp[10] = '{'h4D, 'hF1, 'h40, 'hF9, 'hE1, 'h01, 'hFE01, 'h4000, 0, 0};
    logic [63:0] prod;
    int lat, busyCyc, w;
    bit doneOk;
    for (int i = 0; i < 10; i++) begin
      w = (dSel[i] == 0) ? 4 : 8;
      runOp(dSel[i], dSgn[i], dA[i], dB[i], prod, lat, busyCyc, doneOk);
      vectors += 4;
      if (prod !== dExp[i]) begin miscompares++; $display("[TB] FAIL directed%0d_prod: got %0h expected %0h", i, prod, dExp[i]); end
      if (lat != w) begin miscompares++; $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, lat, w); end
      if (busyCyc != w) begin miscompares++; $display("[TB] FAIL directed%0d_busy: got %0d expected %0d", i, busyCyc, w); end
      if (!doneOk) begin miscompares++; $display("[TB] FAIL directed%0d_done_width: got >1 cycle expected 1", i); end
    end
  endtask

  task automatic test_random();
    logic [63:0] prod, exp;
    logic [31:0] a, b;
    int lat, busyCyc, w;
    bit doneOk, sgn;
    for (int sel = 0; sel < 2; sel++) begin
      w = (sel == 0) ? 4 : 8;
      for (int n = 0; n < 25; n++) begin
        a = $urandom; b = $urandom; sgn = 1'($urandom_range(0, 1));
        exp = refProduct(sgn, w, a, b);
        runOp(sel, sgn, a, b, prod, lat, busyCyc, doneOk);
        vectors += 3;
        if (prod !== exp) begin miscompares++; $display("[TB] FAIL random_w%0d_prod: a=%0h b=%0h s=%0d got %0h expected %0h", w, a & 32'hFF, b & 32'hFF, sgn, prod, exp); end
        if (lat != w) begin miscompares++; $display("[TB] FAIL random_w%0d_latency: got %0d expected %0d", w, lat, w); end
        if (busyCyc != w || !doneOk) begin miscompares++; $display("[TB] FAIL random_w%0d_handshake: busy got %0d expected %0d, doneOk %0d", w, busyCyc, w, doneOk); end
      end
    end
  endtask

  task automatic test_ignore_st();
    int doneCnt = 0;
    int busyCnt;
    logic [63:0] prodAtDone = '0;
    driveStart(0, 1'b0, 7, 11);
    busyCnt = int'(if4.busy);
    setInputs(0, 1'b1, 1'b1, 3, 2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) setSt(0, 1'b0);
      if (if4.done) begin doneCnt++; prodAtDone = curProd(0); end
      busyCnt += int'(if4.busy);
    end
    vectors += 3;
    if (doneCnt != 1) begin miscompares++; $display("[TB] FAIL ignore_st_done_count: got %0d expected 1", doneCnt); end
    if (busyCnt != 4) begin miscompares++; $display("[TB] FAIL ignore_st_busy: got %0d expected 4", busyCnt); end
    if (prodAtDone !== 64'd77) begin miscompares++; $display("[TB] FAIL ignore_st_prod: got %0h expected 4d", prodAtDone); end
  endtask

  task automatic test_midop_reset();
    logic [63:0] prod;
    int lat, busyCyc, doneCnt;
    bit doneOk;
    driveStart(0, 1'b0, 7, 11);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    vectors += 3;
    if (if4.product_o !== 8'h00) begin miscompares++; $display("[TB] FAIL abort_prod: got %0h expected 0", if4.product_o); end
    if (if4.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", if4.busy); end
    if (if4.done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_done: got %b expected 0", if4.done); end
    doneCnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      doneCnt += int'(if4.done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      doneCnt += int'(if4.done);
    end
    vectors++;
    if (doneCnt != 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneCnt); end
    runOp(0, 1'b0, 7, 11, prod, lat, busyCyc, doneOk);
    vectors += 2;
    if (prod !== 64'd77) begin miscompares++; $display("[TB] FAIL restart_prod: got %0h expected 4d", prod); end
    if (lat != 4 || busyCyc != 4) begin miscompares++; $display("[TB] FAIL restart_latency: got %0d/%0d expected 4/4", lat, busyCyc); end
  endtask

  task automatic test_hold();
    logic [63:0] prod, exp;
    int lat, busyCyc, holdBad;
    bit doneOk;
    runOp(0, 1'b0, 9, 9, prod, lat, busyCyc, doneOk);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (curProd(0) !== 64'd81) begin miscompares++; $display("[TB] FAIL hold_idle: got %0h expected 51", curProd(0)); end
    driveStart(0, 1'b1, 5, 3);
    holdBad = (curProd(0) !== 64'd81) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (curProd(0) !== 64'd81) holdBad++;
    end
    vectors++;
    if (holdBad != 0) begin miscompares++; $display("[TB] FAIL hold_calc: got %0d changed samples expected 0", holdBad); end
    @(posedge clk);
    #1;
    exp = refProduct(1'b1, 4, 5, 3);
    vectors++;
    if (!if4.done || curProd(0) !== exp) begin miscompares++; $display("[TB] FAIL hold_update: done %b prod %0h expected done 1 prod %0h", if4.done, curProd(0), exp); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    setInputs(0, 1'b0, 1'b0, 0, 0);
    setInputs(1, 1'b0, 1'b0, 0, 0);
    test_reset();
    test_directed();
    test_ignore_st();
    test_midop_reset();
    test_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
